shift_ex_stage: RTL and testbench

//  Execute-stage wrapper for the 16-bit barrel shifter. Captures shift ops from decode

---
 rtl/shift_ex_stage_pkg.sv | 30 +++
 rtl/shifter.sv | 32 +++
 rtl/shift_ex_stage.sv | 121 ++++++++++++
 tb/tb_shift_ex_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_ex_stage_pkg.sv
// Shared constants and types for the shift execute stage and its decode-side users.
// Operation encodings and operand widths are fixed by the 16-bit shifter datapath.
package shift_ex_stage_pkg;

    localparam int unsigned OPERAND_WIDTH = 16;
    localparam int unsigned SHAMT_WIDTH   = 4;
    localparam int unsigned TAG_WIDTH     = 3;
    localparam int unsigned OPER_WIDTH    = 2;

    typedef enum logic [OPER_WIDTH-1:0] {
        SHOP_ROL = 2'b00,
        SHOP_SLL = 2'b01,
        SHOP_ROR = 2'b10,
        SHOP_SRL = 2'b11
    } shop_e;

    typedef struct packed {
        logic [OPERAND_WIDTH-1:0] data;
        logic [SHAMT_WIDTH-1:0]   shamt;
        shop_e                    oper;
        logic [TAG_WIDTH-1:0]     tag;
    } s1_op_t;

    typedef struct packed {
        logic [OPERAND_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]     tag;
        logic                     zero;
    } res_entry_t;

endpackage

// File: rtl/shifter.sv
// 16-bit logarithmic barrel shifter: rotate or logical shift in either direction.
// One stage per shift-amount bit; each stage moves the word by a power of two.
module shifter
    import shift_ex_stage_pkg::*;
(
    input  logic [OPERAND_WIDTH-1:0] In,
    input  logic [SHAMT_WIDTH-1:0]   ShAmt,
    input  logic [OPER_WIDTH-1:0]    Oper,
    output logic [OPERAND_WIDTH-1:0] Out
);

    logic [OPERAND_WIDTH-1:0] w_stage;

    always_comb begin
        w_stage = In;
        for (int i = 0; i < int'(SHAMT_WIDTH); i++) begin
            if (ShAmt[i]) begin
                case (Oper)
                    SHOP_ROL: w_stage = (w_stage << (1 << i)) |
                                        (w_stage >> (OPERAND_WIDTH - (1 << i)));
                    SHOP_SLL: w_stage = w_stage << (1 << i);
                    SHOP_ROR: w_stage = (w_stage >> (1 << i)) |
                                        (w_stage << (OPERAND_WIDTH - (1 << i)));
                    default:  w_stage = w_stage >> (1 << i);
                endcase
            end
        end
    end

    assign Out = w_stage;

endmodule

// File: rtl/shift_ex_stage.sv
// Execute stage for shift ops: registers the accepted op, shifts it, and queues tagged
// results in an in-order FIFO for writeback/forwarding.
module shift_ex_stage
    import shift_ex_stage_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] in_data,
    input  logic [SHAMT_WIDTH-1:0]   in_shamt,
    input  logic [OPER_WIDTH-1:0]    in_oper,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERAND_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic                     out_zero
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    s1_op_t                   r_s1;
    logic                     r_s1_valid;
    res_entry_t               r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;

    logic [CNT_W:0]           w_occupancy;
    logic                     w_accept;
    logic                     w_push;
    logic                     w_pop;
    logic [OPERAND_WIDTH-1:0] w_shift_out;
    res_entry_t               w_head;
    res_entry_t               w_new_entry;

    // Reserving a slot for the op in S1 lets the S1->FIFO write proceed unconditionally.
    assign w_occupancy = {1'b0, r_count} + (CNT_W+1)'(r_s1_valid);
    assign in_ready    = w_occupancy < (CNT_W+1)'(FIFO_DEPTH);
    assign w_accept    = in_valid & in_ready;
    assign w_push      = r_s1_valid;
    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid & out_ready;

    shifter u_shifter (
        .In    (r_s1.data),
        .ShAmt (r_s1.shamt),
        .Oper  (r_s1.oper),
        .Out   (w_shift_out)
    );

    always_comb begin
        w_new_entry      = '0;
        w_new_entry.data = w_shift_out;
        w_new_entry.tag  = r_s1.tag;
        w_new_entry.zero = (w_shift_out == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1.data  <= in_data;
                r_s1.shamt <= in_shamt;
                r_s1.oper  <= shop_e'(in_oper);
                r_s1.tag   <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage only; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_fifo[r_wr_ptr] <= w_new_entry;
        end
    end

    assign w_head   = r_fifo[r_rd_ptr];
    assign out_data = out_valid ? w_head.data : '0;
    assign out_tag  = out_valid ? w_head.tag  : '0;
    assign out_zero = out_valid ? w_head.zero : 1'b0;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Randomized and directed self-checking bench for shift_ex_stage against a queue-based
// reference model of the accept register and result FIFO.
module tb_shift_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [3:0]  in_shamt;
    logic [1:0]  in_oper;
    logic [2:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [2:0]  out_tag;
    logic        out_zero;

    shift_ex_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_oper   (in_oper),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  t;
    } res_t;

    res_t        m_fifo [$];
    bit          m_s1_v;
    res_t        m_s1;
    int          n_checks;
    int          n_errors;
    int          dut_acc;
    int          dut_pops;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    // One bit position per iteration: ROL/ROR wrap the vacated bit, SLL/SRL insert zero.
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] sh,
                                              input logic [1:0] op);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < int'(sh); i++) begin
            case (op)
                2'b00:   r = {r[14:0], r[15]};
                2'b01:   r = {r[14:0], 1'b0};
                2'b10:   r = {r[0], r[15:1]};
                default: r = {1'b0, r[15:1]};
            endcase
        end
        return r;
    endfunction

    task automatic check_model(input string nm);
        check_eq({nm, "_valid"}, out_valid, (m_fifo.size() != 0));
        check_eq({nm, "_in_ready"}, in_ready, ((m_fifo.size() + int'(m_s1_v)) < 3));
        if (m_fifo.size() != 0) begin
            check_eq({nm, "_data"}, out_data, m_fifo[0].d);
            check_eq({nm, "_tag"}, out_tag, m_fifo[0].t);
            check_eq({nm, "_zero"}, out_zero, (m_fifo[0].d == 16'h0));
        end else begin
            check_eq({nm, "_data0"}, out_data, 0);
            check_eq({nm, "_zero0"}, out_zero, 0);
        end
    endtask

    task automatic step(input bit v, input logic [15:0] d, input logic [3:0] sh,
                        input logic [1:0] op, input logic [2:0] tg, input bit ordy,
                        input bit fl, input string nm);
        bit   m_acc;
        bit   m_pop;
        res_t op_r;
        in_valid  = v;
        in_data   = d;
        in_shamt  = sh;
        in_oper   = op;
        in_tag    = tg;
        out_ready = ordy;
        flush     = fl;
        #1;
        if (v && in_ready) dut_acc++;
        if (out_valid && ordy) dut_pops++;
        m_acc = v && ((m_fifo.size() + int'(m_s1_v)) < 3) && !fl;
        m_pop = (m_fifo.size() != 0) && ordy;
        @(posedge clk);
        #1;
        if (fl) begin
            m_s1_v = 0;
            m_fifo.delete();
        end else begin
            if (m_pop) void'(m_fifo.pop_front());
            if (m_s1_v) m_fifo.push_back(m_s1);
            m_s1_v = m_acc;
            if (m_acc) begin
                op_r.d = ref_shift(d, sh, op);
                op_r.t = tg;
                m_s1   = op_r;
            end
        end
        check_model(nm);
    endtask

    task automatic idle(input bit ordy, input string nm);
        step(1'b0, 16'h0, 4'h0, 2'b00, 3'h0, ordy, 1'b0, nm);
    endtask

    task automatic directed(input string nm, input logic [15:0] d, input logic [3:0] sh,
                            input logic [1:0] op, input logic [2:0] tg,
                            input logic [15:0] exp, input bit expz);
        step(1'b1, d, sh, op, tg, 1'b1, 1'b0, nm);
        check_eq({nm, "_not_yet"}, out_valid, 0);
        idle(1'b1, nm);
        check_eq({nm, "_lat_valid"}, out_valid, 1);
        check_eq({nm, "_res"}, out_data, exp);
        check_eq({nm, "_echo_tag"}, out_tag, tg);
        check_eq({nm, "_zflag"}, out_zero, expz);
        idle(1'b1, nm);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        dut_acc   = 0;
        dut_pops  = 0;
        m_s1_v    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_oper   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #12;
        rst_n = 1'b1;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_tag", out_tag, 0);
        check_eq("rst_zero", out_zero, 0);
        check_eq("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Basic op results, each checked two edges after accept.
        directed("rol", 16'h8001, 4'd1, 2'b00, 3'd1, 16'h0003, 1'b0);
        directed("ror", 16'h0001, 4'd4, 2'b10, 3'd2, 16'h1000, 1'b0);
        directed("sll", 16'hFFFF, 4'd15, 2'b01, 3'd3, 16'h8000, 1'b0);
        directed("srl", 16'h8000, 4'd15, 2'b11, 3'd4, 16'h0001, 1'b0);
        for (int o = 0; o < 4; o++) begin
            directed("sh0", 16'hA5A5, 4'd0, 2'(o), 3'(o), 16'hA5A5, 1'b0);
        end
        directed("nz", 16'h0001, 4'd0, 2'b01, 3'd5, 16'h0001, 1'b0);
        directed("z", 16'h0000, 4'd3, 2'b01, 3'd6, 16'h0000, 1'b1);

        // Back-to-back stream with a ready consumer.
        dut_pops = 0;
        for (int i = 0; i < 8; i++) begin
            check_eq("stream_ready", in_ready, 1);
            step(1'b1, 16'(i * 16'h1111 + 1), 4'(i), 2'(i), 3'(i), 1'b1, 1'b0, "stream");
        end
        idle(1'b1, "stream_tail");
        idle(1'b1, "stream_tail");
        check_eq("stream_pops", dut_pops, 8);

        // Stalled consumer: only three ops fit (two in FIFO, one in S1).
        dut_acc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'h0100 << i, 4'd1, 2'b00, 3'(i), 1'b0, 1'b0, "stall");
        end
        check_eq("stall_accepted", dut_acc, 3);
        check_eq("stall_ready_low", in_ready, 0);
        for (int i = 0; i < 4; i++) idle(1'b1, "release");

        // Flush with S1 occupied, two FIFO entries and an op offered.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'h00F0 + 16'(i), 4'd2, 2'b01, 3'(i), 1'b0, 1'b0, "pre_flush");
        end
        step(1'b1, 16'hBEEF, 4'd1, 2'b10, 3'd7, 1'b0, 1'b1, "flush");
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_ready", in_ready, 1);
        // Flush racing an accept and a pop.
        step(1'b1, 16'h1234, 4'd1, 2'b00, 3'd1, 1'b0, 1'b0, "pre_flush2");
        step(1'b1, 16'h5678, 4'd1, 2'b00, 3'd2, 1'b0, 1'b0, "pre_flush2");
        step(1'b1, 16'h9ABC, 4'd1, 2'b00, 3'd3, 1'b1, 1'b1, "flush2");
        check_eq("flush2_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) idle(1'b1, "post_flush");

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 16'($urandom), 4'($urandom),
                 2'($urandom), 3'($urandom), 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 39) == 0), "rand");
        end
        for (int i = 0; i < 4; i++) idle(1'b1, "drain");

        // Asynchronous reset between clock edges with work in flight.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'hC000 + 16'(i), 4'd3, 2'b11, 3'(i), 1'b0, 1'b0, "pre_rst");
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", out_valid, 0);
        check_eq("arst_data", out_data, 0);
        check_eq("arst_tag", out_tag, 0);
        check_eq("arst_zero", out_zero, 0);
        #2;
        rst_n = 1'b1;
        m_s1_v = 0;
        m_fifo.delete();
        @(posedge clk);
        #1;
        check_model("post_rst");
        directed("after_rst", 16'h0F00, 4'd4, 2'b00, 3'd5, 16'hF000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
